// File: rtl/mem_master_pkg.sv
// Shared types and constants for the mem_master bus-cycle sequencer.
package mem_master_pkg;

    localparam int WAIT_W = 4;
    localparam int STAT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        WAIT   = 3'd3,
        STROBE = 3'd4,
        RDATA  = 3'd5
    } state_e;

    // State that follows the last bus-transfer state (ADDR for a load, DATA for a store).
    function automatic state_e post_xfer_state(input logic has_wait);
        if (has_wait) begin
            return WAIT;
        end else begin
            return STROBE;
        end
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that flags when it has reached zero; paces the WAIT state.
module mem_wait_timer
    import mem_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Next count: load wins over decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {WAIT_W{1'b0}})) begin
            cnt_d = cnt_q - {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {WAIT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {WAIT_W{1'b0}});

endmodule

// File: rtl/mem_master.sv
// Request/response front end that sequences CPU-bus memory cycles
// (address, data, wait, strobe, read-data) on a shared tristate bus.
// Optional macro MEM_MASTER_STATS_EN adds saturating rd_count/wr_count outputs.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int w           = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [w-1:0] req_addr,
    input  logic [w-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [w-1:0] rsp_rdata,
    inout  wire  [w-1:0] bus,
    output logic         MAin,
    output logic         MDbus,
    output logic         MDout,
    output logic         read,
    output logic         write,
    output logic         Wait
`ifdef MEM_MASTER_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count
`endif
);

    localparam logic              HAS_WAIT  = (WAIT_CYCLES > 0);
    // The timer is loaded on entry to WAIT and WAIT exits when it reads zero,
    // so loading WAIT_CYCLES-1 gives exactly WAIT_CYCLES wait cycles.
    localparam logic [WAIT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1)
                                                                : {WAIT_W{1'b0}};

    state_e       state_q, state_d;
    logic         write_q, write_d;
    logic [w-1:0] addr_q, addr_d;
    logic [w-1:0] wdata_q, wdata_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [w-1:0] rsp_rdata_q, rsp_rdata_d;
    logic         tmr_load_s, tmr_dec_s, tmr_zero_s;
    logic         bus_oe_s;
    logic [w-1:0] bus_out_s;

    mem_wait_timer u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (WAIT_LOAD),
        .dec      (tmr_dec_s),
        .zero     (tmr_zero_s)
    );

    // Next-state logic, request capture and response generation.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        tmr_load_s  = 1'b0;
        tmr_dec_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ADDR;
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (write_q) begin
                    state_d = DATA;
                end else begin
                    state_d    = post_xfer_state(HAS_WAIT);
                    tmr_load_s = 1'b1;
                end
            end
            DATA: begin
                state_d    = post_xfer_state(HAS_WAIT);
                tmr_load_s = 1'b1;
            end
            WAIT: begin
                if (tmr_zero_s) begin
                    state_d = STROBE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            STROBE: begin
                if (write_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = bus;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= {w{1'b0}};
            wdata_q     <= {w{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {w{1'b0}};
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Memory-side controls decoded from the state register only.
    always_comb begin
        MAin      = 1'b0;
        MDbus     = 1'b0;
        MDout     = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        Wait      = 1'b0;
        bus_oe_s  = 1'b0;
        bus_out_s = addr_q;
        case (state_q)
            ADDR: begin
                MAin      = 1'b1;
                bus_oe_s  = 1'b1;
                bus_out_s = addr_q;
            end
            DATA: begin
                MDbus     = 1'b1;
                bus_oe_s  = 1'b1;
                bus_out_s = wdata_q;
            end
            WAIT: begin
                read  = !write_q;
                write = write_q;
                Wait  = 1'b1;
            end
            STROBE: begin
                read  = !write_q;
                write = write_q;
            end
            RDATA: begin
                MDout = 1'b1;
            end
            default: begin
                bus_oe_s = 1'b0;
            end
        endcase
    end

    assign bus       = bus_oe_s ? bus_out_s : {w{1'bz}};
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef MEM_MASTER_STATS_EN
    logic [STAT_W-1:0] rd_count_q, rd_count_d;
    logic [STAT_W-1:0] wr_count_q, wr_count_d;

    // Saturating access counters, bumped on each STROBE cycle.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == STROBE) begin
            if (write_q) begin
                if (wr_count_q != {STAT_W{1'b1}}) begin
                    wr_count_d = wr_count_q + {{(STAT_W-1){1'b0}}, 1'b1};
                end else begin
                    wr_count_d = wr_count_q;
                end
            end else begin
                if (rd_count_q != {STAT_W{1'b1}}) begin
                    rd_count_d = rd_count_q + {{(STAT_W-1){1'b0}}, 1'b1};
                end else begin
                    rd_count_d = rd_count_q;
                end
            end
        end else begin
            rd_count_d = rd_count_q;
            wr_count_d = wr_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count_q <= {STAT_W{1'b0}};
            wr_count_q <= {STAT_W{1'b0}};
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: instance A uses WAIT_CYCLES=1, instance B WAIT_CYCLES=0.
module tb_mem_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_wr;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    logic [31:0] last_rd_a = 32'h0;
    logic [31:0] last_rd_b = 32'h0;

    // ---------------- instance A (WAIT_CYCLES=1) ----------------
    logic        rv_a, rw_a;
    logic [31:0] ra_a, wd_a;
    wire         rr_a, sv_a, ma_a, mdb_a, mdo_a, rd_a, wr_a, wt_a;
    wire  [31:0] rsp_a;
    wire  [31:0] bus_a;
`ifdef MEM_MASTER_STATS_EN
    wire  [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
`endif

    mem_master #(.w(32), .WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv_a), .req_ready(rr_a), .req_write(rw_a),
        .req_addr(ra_a), .req_wdata(wd_a),
        .rsp_valid(sv_a), .rsp_rdata(rsp_a), .bus(bus_a),
        .MAin(ma_a), .MDbus(mdb_a), .MDout(mdo_a),
        .read(rd_a), .write(wr_a), .Wait(wt_a)
`ifdef MEM_MASTER_STATS_EN
        , .rd_count(rdc_a), .wr_count(wrc_a)
`endif
    );

    // Memory model A: MAR/MDR latched from the bus, array acted on at strobe.
    bit   [31:0] mem_a [0:255];
    logic [7:0]  mar_a;
    logic [31:0] mdr_a;
    always @(posedge clk) begin
        if (ma_a)         mar_a <= bus_a[7:0];
        if (mdb_a)        mdr_a <= bus_a;
        if (wr_a && !wt_a) mem_a[mar_a] <= mdr_a;
        if (rd_a && !wt_a) mdr_a <= mem_a[mar_a];
    end
    // Drives MDR in RDATA, zeros whenever the DUT must not drive (a stray DUT drive shows up).
    assign bus_a = mdo_a ? mdr_a : ((ma_a | mdb_a) ? 32'hzzzz_zzzz : 32'h0);

    // ---------------- instance B (WAIT_CYCLES=0) ----------------
    logic        rv_b, rw_b;
    logic [31:0] ra_b, wd_b;
    wire         rr_b, sv_b, ma_b, mdb_b, mdo_b, rd_b, wr_b, wt_b;
    wire  [31:0] rsp_b;
    wire  [31:0] bus_b;

    mem_master #(.w(32), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv_b), .req_ready(rr_b), .req_write(rw_b),
        .req_addr(ra_b), .req_wdata(wd_b),
        .rsp_valid(sv_b), .rsp_rdata(rsp_b), .bus(bus_b),
        .MAin(ma_b), .MDbus(mdb_b), .MDout(mdo_b),
        .read(rd_b), .write(wr_b), .Wait(wt_b)
`ifdef MEM_MASTER_STATS_EN
        , .rd_count(rdc_b), .wr_count(wrc_b)
`endif
    );

    // Memory model B: read returns C0DE_00aa for address aa.
    logic [7:0]  mar_b;
    logic [31:0] mdr_b;
    int          wait_b_seen = 0;
    always @(posedge clk) begin
        if (ma_b)          mar_b <= bus_b[7:0];
        if (rd_b && !wt_b) mdr_b <= {24'hC0DE_00, mar_b};
        if (wt_b)          wait_b_seen <= wait_b_seen + 1;
    end
    assign bus_b = mdo_b ? mdr_b : ((ma_b | mdb_b) ? 32'hzzzz_zzzz : 32'h0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: invariants every cycle, scoreboard pop on each response.
    always @(negedge clk) begin
        exp_t e;
        check("a_rd_wr_excl", {31'h0, rd_a & wr_a}, 32'h0);
        check("a_main_mdbus", {31'h0, ma_a & mdb_a}, 32'h0);
        check("a_mdout_drv",  {31'h0, mdo_a & (ma_a | mdb_a)}, 32'h0);
        check("b_rd_wr_excl", {31'h0, rd_b & wr_b}, 32'h0);
        if (mdo_a) check("a_rdata_bus", bus_a, mdr_a);
        if (sv_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_rsp", {31'h0, sv_a}, 32'h0);
            end else begin
                e = q_a.pop_front();
                check(e.is_wr ? "a_st_rdata_hold" : "a_ld_rdata", rsp_a, e.rdata);
                check("a_latency", cyc - e.acc, e.lat);
            end
        end
        if (sv_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_rsp", {31'h0, sv_b}, 32'h0);
            end else begin
                e = q_b.pop_front();
                check(e.is_wr ? "b_st_rdata_hold" : "b_ld_rdata", rsp_b, e.rdata);
                check("b_latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Issue one request on A (called at a negedge); returns at the negedge of the ADDR cycle.
    task automatic issue_a(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_rd, input logic hold,
                           output int acc, output logic rsp_at_acc);
        int n = 0;
        rw_a = wr; ra_a = addr; wd_a = data; rv_a = 1'b1;
        while (!rr_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        rsp_at_acc = sv_a;
        acc = cyc;
        if (!rr_a) begin
            check("a_accept_timeout", {31'h0, rr_a}, 32'h1);
            rv_a = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            q_a.push_back('{is_wr: wr, rdata: (wr ? last_rd_a : exp_rd), acc: cyc, lat: 4});
            if (!wr) last_rd_a = exp_rd;
            if (!hold) begin
                rv_a = 1'b0; rw_a = ~wr; ra_a = 32'hFFFF_FFF0; wd_a = 32'hBAD0_BAD0;
            end
            @(negedge clk);
        end
    endtask

    task automatic issue_b(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_rd);
        int n = 0;
        rw_b = wr; ra_b = addr; wd_b = data; rv_b = 1'b1;
        while (!rr_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rr_b) begin
            check("b_accept_timeout", {31'h0, rr_b}, 32'h1);
            rv_b = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            q_b.push_back('{is_wr: wr, rdata: (wr ? last_rd_b : exp_rd), acc: cyc, lat: 3});
            if (!wr) last_rd_b = exp_rd;
            rv_b = 1'b0; ra_b = 32'hFFFF_FFF0; wd_b = 32'hBAD0_BAD0;
            @(negedge clk);
        end
    endtask

    // Check A's controls {MAin,MDbus,MDout,read,write,Wait} and bus, then advance one cycle.
    task automatic trace_a(input string name, input logic [5:0] exp_ctl, input logic [31:0] exp_bus);
        check(name, {26'h0, ma_a, mdb_a, mdo_a, rd_a, wr_a, wt_a}, {26'h0, exp_ctl});
        check({name, "_bus"}, bus_a, exp_bus);
        @(negedge clk);
    endtask

    initial begin
        int   acc1, acc2;
        logic co;
        rv_a = 1'b0; rw_a = 1'b0; ra_a = 32'h0; wd_a = 32'h0;
        rv_b = 1'b0; rw_b = 1'b0; ra_b = 32'h0; wd_b = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", {31'h0, sv_a}, 32'h0);
        check("rst_rsp_rdata", rsp_a, 32'h0);
        check("rst_ctl", {26'h0, ma_a, mdb_a, mdo_a, rd_a, wr_a, wt_a}, 32'h0);
        check("rst_bus_z", bus_a, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'h0, rr_a}, 32'h1);

        // Store 0x10 <- DEADBEEF, WAIT_CYCLES=1.
        issue_a(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, acc1, co);
        trace_a("st_c1_addr",   6'b100000, 32'h0000_0010);
        trace_a("st_c2_data",   6'b010000, 32'hDEAD_BEEF);
        trace_a("st_c3_wait",   6'b000011, 32'h0);
        trace_a("st_c4_strobe", 6'b000010, 32'h0);
        check("st_c5_rsp", {31'h0, sv_a}, 32'h1);
        check("st_mem_10", mem_a[8'h10], 32'hDEAD_BEEF);

        // Load 0x10, accepted in the store's response cycle.
        issue_a(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, acc1, co);
        trace_a("ld_c1_addr",   6'b100000, 32'h0000_0010);
        trace_a("ld_c2_wait",   6'b000101, 32'h0);
        trace_a("ld_c3_strobe", 6'b000100, 32'h0);
        trace_a("ld_c4_rdata",  6'b001000, 32'hDEAD_BEEF);
        check("ld_c5_rsp", {31'h0, sv_a}, 32'h1);
        @(negedge clk);

        // Back-to-back store 0x4 <- 0x1234 then load 0x4, req_valid held high.
        issue_a(1'b1, 32'h4, 32'h0000_1234, 32'h0, 1'b1, acc1, co);
        issue_a(1'b0, 32'h4, 32'h0, 32'h0000_1234, 1'b0, acc2, co);
        check("b2b_accept_on_rsp", {31'h0, co}, 32'h1);
        check("b2b_gap", acc2 - acc1, 32'd5);
        repeat (6) @(negedge clk);

        // Reset during the WAIT cycle of a store to 0x20.
        issue_a(1'b1, 32'h20, 32'h5555_AAAA, 32'h0, 1'b0, acc1, co);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_in_wait", {31'h0, wt_a}, 32'h1);
        rst_n = 1'b0;
        q_a.delete();
        @(negedge clk);
        check("rst_mid_ready", {31'h0, rr_a}, 32'h1);
        check("rst_mid_ctl", {26'h0, ma_a, mdb_a, mdo_a, rd_a, wr_a, wt_a}, 32'h0);
        check("rst_mid_bus_z", bus_a, 32'h0);
        check("rst_mid_rsp", {31'h0, sv_a}, 32'h0);
        check("rst_mid_rdata", rsp_a, 32'h0);
        rst_n = 1'b1;
        last_rd_a = 32'h0;
        repeat (6) @(negedge clk);
        check("rst_mid_mem_20", mem_a[8'h20], 32'h0);
        check("rst_mid_mem_10", mem_a[8'h10], 32'hDEAD_BEEF);
        issue_a(1'b0, 32'h20, 32'h0, 32'h0, 1'b0, acc1, co);
        issue_a(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, acc1, co);
        repeat (6) @(negedge clk);

        // WAIT_CYCLES=0: loads and a store with latency 3 and no Wait.
        issue_b(1'b0, 32'h3, 32'h0, 32'hC0DE_0003);
        issue_b(1'b1, 32'h8, 32'h0000_0077, 32'h0);
        issue_b(1'b0, 32'h7, 32'h0, 32'hC0DE_0007);
        repeat (6) @(negedge clk);
        check("b_no_wait", wait_b_seen, 32'h0);

        check("a_queue_drained", q_a.size(), 32'h0);
        check("b_queue_drained", q_b.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
